// File: rtl/kgp_control_fsm.sv
// Multi-cycle main control FSM for the KGP-RISC datapath.
// Every output is a flop loaded from the next-state decode, so no input reaches an output combinationally.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_FETCH  | instr_ready high, waiting for instr_valid
// S_DECODE | opcode latched, ALUOp/func_code presented
// S_EXEC   | ALU operating; branch/jump resolve the PC here
// S_MEM    | load/store in flight, bounded by MEM_TIMEOUT
// S_WB     | register write-back and PC+4 update
// S_HALT   | absorbing stop (HALT opcode, illegal func, memory timeout)
module kgp_control_fsm #(
  parameter int FUNC_W      = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [31:0]       instr_i,
  input  logic              instr_valid_i,
  output logic              instr_ready_o,
  input  logic              mem_ready_i,
  input  logic              zero_flag_i,
  output logic [2:0]        alu_op_o,
  output logic [FUNC_W-1:0] func_code_o,
  output logic              reg_write_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic              pc_write_o,
  output logic [1:0]        pc_src_o,
  output logic              halted_o,
  output logic              error_o
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [2:0] OP_RTYPE  = 3'd0;
  localparam logic [2:0] OP_IMM    = 3'd1;
  localparam logic [2:0] OP_LOAD   = 3'd2;
  localparam logic [2:0] OP_STORE  = 3'd3;
  localparam logic [2:0] OP_BRZ    = 3'd4;
  localparam logic [2:0] OP_SHIFT  = 3'd5;
  localparam logic [2:0] OP_JUMP   = 3'd6;
  localparam logic [2:0] OP_HALT   = 3'd7;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [FUNC_W-1:0] FUNC_ONE = {{(FUNC_W-1){1'b0}}, 1'b1};

  logic [2:0]        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        alu_op_q, alu_op_d;
  logic [FUNC_W-1:0] func_q, func_d;
  logic              error_q, error_d;
  logic              reg_write_d, pc_write_d;
  logic [1:0]        pc_src_d;
  logic              instr_ready_q, reg_write_q, mem_read_q, mem_write_q;
  logic              pc_write_q, halted_q;
  logic [1:0]        pc_src_q;
  logic              func_onehot;

  function automatic logic [2:0] alu_class(input logic [2:0] op);
    case (op)
      OP_RTYPE: alu_class = 3'd0;
      OP_IMM:   alu_class = 3'd1;
      OP_LOAD:  alu_class = 3'd3;
      OP_STORE: alu_class = 3'd3;
      OP_BRZ:   alu_class = 3'd4;
      OP_SHIFT: alu_class = 3'd5;
      OP_JUMP:  alu_class = 3'd6;
      default:  alu_class = 3'd0;
    endcase
  endfunction

  assign func_onehot = (func_q != '0) && ((func_q & (func_q - FUNC_ONE)) == '0);

  // Pulses are registered on the edge where the decision is made, so a branch,
  // jump or store PC update is visible in the first FETCH cycle that follows.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    alu_op_d    = alu_op_q;
    func_d      = func_q;
    error_d     = error_q;
    reg_write_d = 1'b0;
    pc_write_d  = 1'b0;
    pc_src_d    = PC_SEQ;
    case (state_q)
      S_FETCH: begin
        if (instr_valid_i && instr_ready_q) begin
          op_d     = instr_i[31:29];
          alu_op_d = alu_class(instr_i[31:29]);
          func_d   = (instr_i[31:29] == OP_RTYPE) ? instr_i[FUNC_W-1:0] : '0;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op_q == OP_HALT) begin
          state_d = S_HALT;
        end else if (op_q == OP_RTYPE && !func_onehot) begin
          state_d = S_HALT;
          error_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_BRZ: begin
            pc_write_d = 1'b1;
            pc_src_d   = zero_flag_i ? PC_BRANCH : PC_SEQ;
            state_d    = S_FETCH;
          end
          OP_JUMP: begin
            pc_write_d = 1'b1;
            pc_src_d   = PC_JUMP;
            state_d    = S_FETCH;
          end
          OP_LOAD, OP_STORE: begin
            cnt_d   = CNT_LOAD;
            state_d = S_MEM;
          end
          default: begin
            reg_write_d = 1'b1;
            pc_write_d  = 1'b1;
            state_d     = S_WB;
          end
        endcase
      end
      S_MEM: begin
        // mem_ready is checked first so it wins over a coincident timeout
        if (mem_ready_i) begin
          pc_write_d = 1'b1;
          if (op_q == OP_LOAD) begin
            reg_write_d = 1'b1;
            state_d     = S_WB;
          end else begin
            state_d = S_FETCH;
          end
        end else if (cnt_q == '0) begin
          state_d = S_HALT;
          error_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    if (state_d == S_FETCH || state_d == S_HALT) begin
      alu_op_d = '0;
      func_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_FETCH;
      op_q          <= '0;
      cnt_q         <= '0;
      alu_op_q      <= '0;
      func_q        <= '0;
      error_q       <= 1'b0;
      instr_ready_q <= 1'b0;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      pc_write_q    <= 1'b0;
      pc_src_q      <= PC_SEQ;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      cnt_q         <= cnt_d;
      alu_op_q      <= alu_op_d;
      func_q        <= func_d;
      error_q       <= error_d;
      instr_ready_q <= (state_d == S_FETCH);
      reg_write_q   <= reg_write_d;
      mem_read_q    <= (state_d == S_MEM) && (op_d == OP_LOAD);
      mem_write_q   <= (state_d == S_MEM) && (op_d == OP_STORE);
      pc_write_q    <= pc_write_d;
      pc_src_q      <= pc_src_d;
      halted_q      <= (state_d == S_HALT);
    end
  end

  assign instr_ready_o = instr_ready_q;
  assign alu_op_o      = alu_op_q;
  assign func_code_o   = func_q;
  assign reg_write_o   = reg_write_q;
  assign mem_read_o    = mem_read_q;
  assign mem_write_o   = mem_write_q;
  assign pc_write_o    = pc_write_q;
  assign pc_src_o      = pc_src_q;
  assign halted_o      = halted_q;
  assign error_o       = error_q;

endmodule

// File: tb/tb_kgp_control_fsm.sv
// Randomized bench for kgp_control_fsm against an instruction-level timing/enable model.
module tb_kgp_control_fsm;
  localparam int FUNC_W = 8;
  localparam int MEM_TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        mem_ready = 1'b0;
  logic        zero_flag = 1'b0;
  logic        instr_ready, reg_write, mem_read, mem_write, pc_write, halted, error;
  logic [2:0]  alu_op;
  logic [7:0]  func_code;
  logic [1:0]  pc_src;

  int checks = 0;
  int errors = 0;
  int alu_tab[8] = '{0, 1, 3, 3, 4, 5, 6, 0};

  kgp_control_fsm #(.FUNC_W(FUNC_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .instr_i(instr), .instr_valid_i(instr_valid),
    .instr_ready_o(instr_ready), .mem_ready_i(mem_ready), .zero_flag_i(zero_flag),
    .alu_op_o(alu_op), .func_code_o(func_code), .reg_write_o(reg_write),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .pc_write_o(pc_write),
    .pc_src_o(pc_src), .halted_o(halted), .error_o(error)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] all_outs();
    return 32'({instr_ready, alu_op, func_code, reg_write, mem_read, mem_write,
                pc_write, pc_src, halted, error});
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input logic [7:0] f);
    logic [20:0] mid;
    mid = 21'($urandom);
    return {3'(op), mid, f};
  endfunction

  // Instruction-level model: latency to the next instr_ready (or to halted),
  // enable pulse counts and memory-access cycles, from opcode/func/zero/wait count.
  task automatic model(input logic [31:0] ins, input bit zf, input int n,
                       output int lat, output bit hlt, output bit err,
                       output int rw, output int pw, output int src,
                       output int mrd, output int mwr, output int alu, output int fn);
    int op;
    logic [7:0] f;
    op = int'(ins[31:29]);
    f = ins[7:0];
    hlt = 0; err = 0; rw = 0; pw = 0; src = 0; mrd = 0; mwr = 0;
    alu = alu_tab[op];
    fn = (op == 0) ? int'(f) : 0;
    lat = 0;
    if (op == 7) begin
      hlt = 1; lat = 2;
    end else if (op == 0 && $countones(f) != 1) begin
      hlt = 1; err = 1; lat = 2;
    end else if (op == 4 || op == 6) begin
      lat = 3; pw = 1;
      src = (op == 6) ? 2 : (zf ? 1 : 0);
    end else if (op == 2 || op == 3) begin
      int cyc;
      if (n >= MEM_TIMEOUT) begin
        hlt = 1; err = 1; cyc = MEM_TIMEOUT; lat = 2 + MEM_TIMEOUT + 1;
      end else begin
        cyc = n + 1; pw = 1;
        rw = (op == 2) ? 1 : 0;
        lat = (op == 2) ? 5 + n : 4 + n;
      end
      if (op == 2) mrd = cyc; else mwr = cyc;
    end else begin
      lat = 4; rw = 1; pw = 1;
    end
  endtask

  task automatic run_instr(input string tag, input logic [31:0] ins, input bit zf, input int n);
    int e_lat, e_rw, e_pw, e_src, e_mrd, e_mwr, e_alu, e_fn;
    bit e_hlt, e_err, done, rdy_seen;
    int cyc, rw_cnt, rw_at, pw_cnt, src_seen, mrd_cnt, mwr_cnt, alu_bad, fn_bad;
    model(ins, zf, n, e_lat, e_hlt, e_err, e_rw, e_pw, e_src, e_mrd, e_mwr, e_alu, e_fn);
    rdy_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (instr_ready) begin rdy_seen = 1; break; end
    end
    check({tag, "_ready_wait"}, 32'(rdy_seen), 32'd1);
    if (!rdy_seen) return;
    instr = ins; instr_valid = 1'b1; zero_flag = zf;
    cyc = 0; rw_cnt = 0; rw_at = 0; pw_cnt = 0; src_seen = 0;
    mrd_cnt = 0; mwr_cnt = 0; alu_bad = 0; fn_bad = 0; done = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      cyc++;
      if (reg_write) begin rw_cnt++; rw_at = cyc; end
      if (pc_write) begin pw_cnt++; src_seen = int'(pc_src); end
      if (mem_read || mem_write) mem_ready = ((mrd_cnt + mwr_cnt) == n);
      else mem_ready = 1'($urandom);
      if (mem_read) mrd_cnt++;
      if (mem_write) mwr_cnt++;
      if (!instr_ready && !halted) begin
        if (int'(alu_op) != e_alu) alu_bad++;
        if (int'(func_code) != e_fn) fn_bad++;
      end
      if (instr_ready || halted) begin done = 1; break; end
      instr_valid = 1'($urandom);
      instr = $urandom;
    end
    instr_valid = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(e_lat));
    check({tag, "_halted"}, 32'(halted), 32'(e_hlt));
    check({tag, "_error"}, 32'(error), 32'(e_err));
    check({tag, "_reg_write_cnt"}, 32'(rw_cnt), 32'(e_rw));
    check({tag, "_pc_write_cnt"}, 32'(pc_write ? pw_cnt : pw_cnt), 32'(e_pw));
    check({tag, "_mem_read_cyc"}, 32'(mrd_cnt), 32'(e_mrd));
    check({tag, "_mem_write_cyc"}, 32'(mwr_cnt), 32'(e_mwr));
    check({tag, "_alu_op_hold"}, 32'(alu_bad), 32'd0);
    check({tag, "_func_hold"}, 32'(fn_bad), 32'd0);
    if (e_pw > 0) check({tag, "_pc_src"}, 32'(src_seen), 32'(e_src));
    if (e_rw > 0) check({tag, "_reg_write_at"}, 32'(rw_at), 32'(e_lat - 1));
    if (!e_hlt) check({tag, "_fetch_alu_clear"}, 32'({alu_op, func_code}), 32'd0);
  endtask

  task automatic halt_hold(input string tag);
    instr_valid = 1'b1;
    instr = mk(1, 8'h00);
    repeat (4) @(negedge clk);
    instr_valid = 1'b0;
    check({tag, "_absorbing"}, all_outs(), 32'({halted, error}));
    check({tag, "_still_halted"}, 32'(halted), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs_zero", all_outs(), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] f;
    // Reset held with a valid instruction offered
    instr_valid = 1'b1;
    instr = mk(1, 8'h00);
    repeat (3) @(negedge clk);
    check("reset_hold_outputs", all_outs(), 32'd0);
    rst_n = 1'b1;
    #1 check("reset_release_ready_low", 32'(instr_ready), 32'd0);
    @(negedge clk);
    check("reset_first_edge_ready", 32'(instr_ready), 32'd1);
    check("reset_first_edge_alu", 32'(alu_op), 32'd0);
    instr_valid = 1'b0;

    run_instr("rtype_04", mk(0, 8'h04), 1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      f = 8'd1 << i;
      run_instr("rtype_sweep", mk(0, f), 1'($urandom), 0);
    end
    run_instr("imm", mk(1, 8'($urandom)), 1'b0, 0);
    run_instr("load_n0", mk(2, 8'($urandom)), 1'b0, 0);
    run_instr("store_n2", mk(3, 8'($urandom)), 1'b1, 2);
    run_instr("brz_taken", mk(4, 8'($urandom)), 1'b1, 0);
    run_instr("brz_not", mk(4, 8'($urandom)), 1'b0, 0);
    run_instr("shift", mk(5, 8'($urandom)), 1'b1, 0);
    run_instr("jump", mk(6, 8'($urandom)), 1'b0, 0);
    run_instr("load_stall4", mk(2, 8'h00), 1'b0, 4);
    run_instr("load_edge14", mk(2, 8'h00), 1'b0, MEM_TIMEOUT - 1);

    for (int i = 0; i < 40; i++) begin
      int op;
      op = $urandom_range(0, 6);
      f = (op == 0) ? 8'(8'd1 << $urandom_range(0, 7)) : 8'($urandom);
      run_instr("random", mk(op, f), 1'($urandom), $urandom_range(0, 6));
    end

    run_instr("illegal_func03", mk(0, 8'h03), 1'b0, 0);
    halt_hold("illegal_func03");
    do_reset();
    run_instr("illegal_func00", mk(0, 8'h00), 1'b0, 0);
    do_reset();
    run_instr("store_timeout", mk(3, 8'h00), 1'b0, 1000);
    halt_hold("store_timeout");
    do_reset();
    run_instr("load_timeout", mk(2, 8'h00), 1'b0, MEM_TIMEOUT);
    do_reset();
    run_instr("halt_op7", mk(7, 8'($urandom)), 1'b0, 0);
    halt_hold("halt_op7");
    do_reset();

    // Reset pulsed while a store waits on memory
    for (int k = 0; k < 10 && !instr_ready; k++) @(negedge clk);
    instr = mk(3, 8'h00); instr_valid = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("midmem_write_active", 32'(mem_write), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("midmem_async_drop", all_outs(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midmem_restart_ready", 32'(instr_ready), 32'd1);
    run_instr("after_midmem", mk(0, 8'h10), 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
